// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: shared types, opcodes and immediate generation for the multi-cycle RV32I core
package riscv_mc_pkg;
   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
   typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_PASSB} alu_op_t;
   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   typedef struct packed {
      alu_op_t alu_op;
      imm_t    imm_type;
      logic    src_imm;
      logic    is_load;
      logic    is_store;
      logic    is_branch;
      logic    is_jal;
      logic    reg_write;
      logic    illegal;
   } ctrl_t;
   function automatic logic [31:0] imm_gen(input logic [31:0] ir, input imm_t t);
      return t == IMM_S ? {{20{ir[31]}}, ir[31:25], ir[11:7]} :
             t == IMM_B ? {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0} :
             t == IMM_U ? {ir[31:12], 12'b0} :
             t == IMM_J ? {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0} :
                          {{20{ir[31]}}, ir[31:20]};
   endfunction
endpackage

// File: rtl/riscv_mc_mem_if.sv
// riscv_mc_mem_if: unified instruction/data memory port with req/ready handshake
interface riscv_mc_mem_if #(parameter int ADDR_W = 32);
   logic              req;
   logic              we;
   logic              ready;
   logic [ADDR_W-1:0] addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   modport master (output req, we, addr, wdata, input rdata, ready);
   modport slave  (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/riscv_mc_decoder.sv
// riscv_mc_decoder: combinational IR decode into control fields, flags illegal encodings and register indices
module riscv_mc_decoder import riscv_mc_pkg::*; #(
   parameter int NUM_REGS = 32
) (
   input  logic [31:0] ir,
   output ctrl_t       ctrl
);
   logic [2:0] f3;
   logic [6:0] f7;
   logic       rs1_ok, rs2_ok, rd_ok, f3_alu;
   alu_op_t    f3_op;
   assign f3     = ir[14:12];
   assign f7     = ir[31:25];
   assign rd_ok  = int'(ir[11:7]) < NUM_REGS;
   assign rs1_ok = int'(ir[19:15]) < NUM_REGS;
   assign rs2_ok = int'(ir[24:20]) < NUM_REGS;
   assign f3_alu = f3 inside {3'b000, 3'b010, 3'b110, 3'b111};
   assign f3_op  = f3 == 3'b111 ? ALU_AND : f3 == 3'b110 ? ALU_OR : f3 == 3'b010 ? ALU_SLT : ALU_ADD;
   // only the register fields an instruction actually uses are range-checked
   always_comb begin
      ctrl = '0;
      ctrl.illegal = 1'b1;
      case (ir[6:0])
         OP: begin
            ctrl.alu_op    = f7[5] ? ALU_SUB : f3_op;
            ctrl.reg_write = 1'b1;
            ctrl.illegal   = !((f7 == 7'b0000000 && f3_alu) || (f7 == 7'b0100000 && f3 == 3'b000)) ||
                             !(rs1_ok && rs2_ok && rd_ok);
         end
         OP_IMM: begin
            ctrl.alu_op    = f3_op;
            ctrl.src_imm   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.illegal   = !f3_alu || !(rs1_ok && rd_ok);
         end
         LOAD: begin
            ctrl.is_load   = 1'b1;
            ctrl.src_imm   = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.illegal   = f3 != 3'b010 || !(rs1_ok && rd_ok);
         end
         STORE: begin
            ctrl.is_store = 1'b1;
            ctrl.src_imm  = 1'b1;
            ctrl.imm_type = IMM_S;
            ctrl.illegal  = f3 != 3'b010 || !(rs1_ok && rs2_ok);
         end
         BRANCH: begin
            ctrl.is_branch = 1'b1;
            ctrl.imm_type  = IMM_B;
            ctrl.illegal   = f3[2:1] != 2'b00 || !(rs1_ok && rs2_ok);
         end
         JAL: begin
            ctrl.is_jal    = 1'b1;
            ctrl.imm_type  = IMM_J;
            ctrl.reg_write = 1'b1;
            ctrl.illegal   = !rd_ok;
         end
         LUI: begin
            ctrl.alu_op    = ALU_PASSB;
            ctrl.src_imm   = 1'b1;
            ctrl.imm_type  = IMM_U;
            ctrl.reg_write = 1'b1;
            ctrl.illegal   = !rd_ok;
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/riscv_multicycle_core.sv
// riscv_multicycle_core: multi-cycle RV32I-subset core on a shared stallable memory port
// Optional performance counters under RISCV_MC_PERF_COUNTERS_EN.
module riscv_multicycle_core import riscv_mc_pkg::*; #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                NUM_REGS = 32
) (
   input  logic              clk,
   input  logic              reset,
   riscv_mc_mem_if.master    mem,
   output logic              retire,
   output logic              halted,
   output logic [ADDR_W-1:0] pc_dbg
`ifdef RISCV_MC_PERF_COUNTERS_EN
   ,
   output logic [63:0]       cycle_cnt,
   output logic [63:0]       instret_cnt,
   output logic [31:0]       stall_cnt
`endif
);
   state_t            state, state_nx;
   ctrl_t             ctrl;
   logic [31:0]       ir, a, b, alu_out, imm, src_b, alu_y;
   logic [31:0]       regs [32];
   logic [ADDR_W-1:0] pc, pc_plus4, pc_target;
   logic              taken;
   riscv_mc_decoder #(.NUM_REGS(NUM_REGS)) u_dec (.ir(ir), .ctrl(ctrl));
   assign imm       = imm_gen(ir, ctrl.imm_type);
   assign src_b     = ctrl.src_imm ? imm : b;
   assign pc_plus4  = pc + ADDR_W'(4);
   assign pc_target = pc + imm[ADDR_W-1:0];
   assign taken     = ir[12] ? a != b : a == b;
   assign pc_dbg    = pc;
   assign alu_y = ctrl.alu_op == ALU_SUB   ? a - src_b :
                  ctrl.alu_op == ALU_AND   ? a & src_b :
                  ctrl.alu_op == ALU_OR    ? a | src_b :
                  ctrl.alu_op == ALU_SLT   ? {31'b0, $signed(a) < $signed(src_b)} :
                  ctrl.alu_op == ALU_PASSB ? src_b : a + src_b;
   always_comb begin
      state_nx  = state;
      mem.req   = !reset && (state == FETCH || state == MEM);
      mem.we    = state == MEM && ctrl.is_store;
      mem.addr  = (state == MEM ? alu_out[ADDR_W-1:0] : pc) & ~ADDR_W'(3);
      mem.wdata = b;
      retire    = !reset && (state == WB || (state == EXEC && ctrl.is_branch) ||
                             (state == MEM && ctrl.is_store && mem.ready));
      halted    = state == HALT;
      case (state)
         FETCH:   state_nx = mem.ready ? DECODE : FETCH;
         DECODE:  state_nx = ctrl.illegal ? HALT : EXEC;
         EXEC:    state_nx = ctrl.is_branch ? FETCH :
                             !(ctrl.is_load || ctrl.is_store) ? WB :
                             alu_y[1:0] != 2'b00 ? HALT : MEM;
         MEM:     state_nx = !mem.ready ? MEM : ctrl.is_store ? FETCH : WB;
         WB:      state_nx = FETCH;
         default: state_nx = HALT;
      endcase
   end
   // load data reuses alu_out so WB always writes the same register
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= FETCH;
         pc      <= RESET_PC;
         ir      <= NOP;
         a       <= '0;
         b       <= '0;
         alu_out <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         state <= state_nx;
         if (state == FETCH && mem.ready) ir <= mem.rdata;
         if (state == DECODE) begin
            a <= regs[ir[19:15]];
            b <= regs[ir[24:20]];
         end
         if (state == EXEC) alu_out <= ctrl.is_jal ? 32'(pc_plus4) : alu_y;
         if (state == MEM && mem.ready && !ctrl.is_store) alu_out <= mem.rdata;
         if (state == EXEC && (ctrl.is_branch || ctrl.is_jal)) pc <= (ctrl.is_jal || taken) ? pc_target : pc_plus4;
         else if (retire && !ctrl.is_jal) pc <= pc_plus4;
         if (state == WB && ctrl.reg_write && ir[11:7] != 5'd0) regs[ir[11:7]] <= alu_out;
      end
   end
`ifdef RISCV_MC_PERF_COUNTERS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         cycle_cnt   <= '0;
         instret_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         if (state != HALT) cycle_cnt <= cycle_cnt + 64'd1;
         if (retire) instret_cnt <= instret_cnt + 64'd1;
         if (mem.req && !mem.ready) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: doc/riscv_multicycle_core.md
Name: riscv_multicycle_core

Overview:
- Parametrised multi-cycle RV32I-subset core; successor to the single-cycle processor top.
- Uses a single unified memory port with a req/ready handshake, so memory can stall the core; instruction fetch and data access share the port.
- Holds fetched instruction in an IR; sequences FETCH/DECODE/EXEC/MEM/WB with an FSM.
- Adds load/store, JAL, LUI, BNE, illegal-instruction halt and retire reporting.

Parameters:
- ADDR_W, 32, memory address and PC width (<=32). PC arithmetic wraps modulo 2^ADDR_W.
- RESET_PC, 0, PC value loaded on reset; must be 4-byte aligned.
- NUM_REGS, 32, architectural registers; 16 gives RV32E. Any rs1/rs2/rd index >= NUM_REGS is illegal.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- mem_req  out  1  memory transaction request
- mem_we  out  1  1=store, 0=read (fetch or load)
- mem_addr  out  ADDR_W  byte address, always word aligned
- mem_wdata  out  32  store data (rs2)
- mem_rdata  in  32  read data, valid in the cycle mem_ready=1
- mem_ready  in  1  transaction completes on the edge where mem_req&&mem_ready
- retire  out  1  one-cycle pulse when an instruction completes
- halted  out  1  core stopped in HALT; sticky until reset
- pc_dbg  out  ADDR_W  current architectural PC

Behaviour:
- Reset, sampled at the clock edge:
  - pc=RESET_PC; state=FETCH; IR=0x00000013 (NOP).
  - All registers x1..x(NUM_REGS-1) = 0.
  - retire=0, halted=0. mem_req is forced 0 while reset=1.
- Handshake:
  - mem_req is high only in FETCH and MEM.
  - mem_addr, mem_we and mem_wdata are held stable until the mem_ready edge.
  - mem_ready with mem_req=0 is ignored.
  - Reset mid-transaction abandons the transaction with no side effects.
- State transitions:
  - FETCH: mem_addr=pc, we=0. On ready, IR<=mem_rdata and go to DECODE.
  - DECODE: read rs1/rs2 into A/B, compute immediate. An illegal opcode/funct or an index >= NUM_REGS goes to HALT; otherwise go to EXEC.
  - EXEC: ALU result goes to register ALUOut.
    - BEQ/BNE: pc <= taken ? pc+immB : pc+4; retire; go to FETCH.
    - JAL: rd<=pc+4, pc<=pc+immJ, then WB.
    - LW/SW: address = rs1+immI/immS. addr[1:0]!=0 goes to HALT; otherwise go to MEM.
    - All other instructions go to WB.
  - MEM: LW reads (we=0) and goes to WB on ready. SW writes (we=1) on ready, then pc+=4, retire, go to FETCH.
  - WB: write rd (ALUOut or load data); pc+=4 (JAL already updated pc); retire; go to FETCH.
  - HALT: halted=1, mem_req=0; only reset exits.
- Supported instructions: ADD, SUB, AND, OR, SLT, ADDI, ANDI, ORI, SLTI, LUI, LW, SW, BEQ, BNE, JAL.
- Arithmetic: SLT/SLTI compare signed 32-bit; immediates are sign-extended to 32 bits.
- Writes to x0 are discarded; x0 always reads 0.
- Latency with zero-wait memory (mem_ready tied high): ALU/LUI/JAL 4 cycles, LW 5, SW 4, branch 3. Each wait cycle adds 1.
- retire pulses in the cycle the instruction completes. PC wrap at 2^ADDR_W is silent.

Optional Feature:
- Macro: RISCV_MC_PERF_COUNTERS_EN
- When defined, adds:
  - Output cycle_cnt[63:0]: +1 every non-reset cycle, counting stopped at HALT.
  - Output instret_cnt[63:0]: +1 on every retire.
  - Output stall_cnt[31:0]: +1 per cycle with mem_req&&!mem_ready.
  - All counters reset to 0 and wrap silently.
- When undefined, the ports and logic do not exist; behaviour is otherwise identical.

Decomposition:
- Package riscv_mc_pkg holds:
  - State enum {FETCH, DECODE, EXEC, MEM, WB, HALT}.
  - Opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, LUI).
  - alu_op_t enum.
  - NOP constant 0x00000013.
- Sub-module riscv_mc_decoder: combinational decode of IR into a control struct (alu_op, imm_type, is_load/store/branch/jal, reg_write, illegal).
- Register file and ALU stay inline in the core.

Test Plan:
- Reset, RESET_PC=0x100, zero-wait memory -> first mem_req with mem_addr=0x100 in the first post-reset cycle. ADDI x1,x0,5 retires after 4 cycles with x1=5.
- Memory word[0x40]=0xDEADBEEF, LW x2,0x40(x0); SW x2,0x44(x0) -> store has mem_we=1, addr=0x44, wdata=0xDEADBEEF. LW takes 5 cycles.
- mem_ready low for 3 cycles during fetch -> mem_addr/mem_req held stable; ADDI retire delayed by exactly 3 cycles. Stall_cnt=3 with the macro defined.
- BNE x1,x0,-8 with x1=5 -> next fetch at pc-8. BEQ with the same operands -> next fetch at pc+4. Each branch retires in 3 cycles.
- IR=0xFFFFFFFF, or ADD x17 with NUM_REGS=16, or LW to address 0x42 -> halted=1, mem_req=0 forever, no register/memory write. Reset clears halted.
- ADDI x0,x0,7 then ADD x3,x0,x0 -> x3=0. JAL x1,+16 at 0x200 -> x1=0x204, next fetch 0x210.
